// File: rtl/mezclador_dac_pkg.sv
// Shared fixed-point constants, FSM encoding and DAC code helper for the
// three-band mixer with serial DAC output.
package mezclador_dac_pkg;

  localparam int PKG_P       = 10;
  localparam int PKG_F       = 14;
  localparam int PKG_WIDTH   = PKG_P + PKG_F + 1;
  localparam int PKG_GW      = 16;
  localparam int FRAC_SHIFT  = 14;
  localparam int DAC_BITS    = 12;
  localparam int DAC_OFFSET  = 2048;
  localparam int FRAME_BITS  = 16;
  // Mix is clamped to -16384..16383 before scaling to a 12-bit offset code.
  localparam int DAC_CLAMP_W = DAC_BITS + 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_SAT   = 2'd2,
    ST_SHIFT = 2'd3
  } state_t;

  // Arithmetic >>>3 then +2048; adding the offset modulo 2^12 maps -2048..2047 onto 0..4095.
  function automatic logic [DAC_BITS-1:0] dac_code(input logic [DAC_CLAMP_W-1:0] ys);
    return ys[DAC_CLAMP_W-1:3] + DAC_BITS'(DAC_OFFSET);
  endfunction

endpackage

// File: rtl/mezclador_dac_saturacion.sv
// Signed saturating narrow: IN_W two's-complement value clamped into OUT_W bits.
module saturacion
  import mezclador_dac_pkg::*;
#(
  parameter int IN_W  = 43,
  parameter int OUT_W = 25
) (
  input  logic [IN_W-1:0]  d_i,
  output logic [OUT_W-1:0] q_o
);

  logic [IN_W-OUT_W:0] upper;
  logic                in_range;

  // In range exactly when every bit above the output sign bit matches it.
  always_comb begin
    upper    = d_i[IN_W-1:OUT_W-1];
    in_range = (&upper) | ~(|upper);
    if (in_range) begin
      q_o = d_i[OUT_W-1:0];
    end else if (d_i[IN_W-1]) begin
      q_o = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      q_o = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/mezclador_dac.sv
// Three-band gain mixer: one shared multiplier over three MAC cycles,
// saturation to Q10.14, then a 16-bit MSB-first frame to a serial DAC.
module mezclador_dac
  import mezclador_dac_pkg::*;
#(
  parameter int p     = PKG_P,
  parameter int f     = PKG_F,
  parameter int Width = p + f + 1,
  parameter int GW    = PKG_GW
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             enable,
  input  logic [Width-1:0] yk_HPBass,
  input  logic [Width-1:0] yk_HPMed,
  input  logic [Width-1:0] yk_HPHigh,
  input  logic [GW-1:0]    g_bass,
  input  logic [GW-1:0]    g_med,
  input  logic [GW-1:0]    g_high,
  output logic [Width-1:0] yk_mix,
  output logic             mix_valid,
  output logic             dac_cs_n,
  output logic             dac_din,
  output logic             busy,
  output logic             overrun,
  output logic [1:0]       dbg_state_o
);

  localparam int PROD_W = Width + GW;
  localparam int ACC_W  = PROD_W + 2;
  localparam int CNT_W  = $clog2(FRAME_BITS);

  // Handshake: enable is a single-cycle strobe with no ready; it is accepted only
  // in IDLE, otherwise dropped and recorded in overrun. mix_valid is a one-cycle
  // pulse qualifying yk_mix, which holds until the next pulse.

  state_t                  state_q, state_d;
  logic signed [Width-1:0] band_q [3];
  logic signed [GW-1:0]    gain_q [3];
  logic [1:0]              idx_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [Width-1:0]        yk_mix_q;
  logic                    mix_valid_q;
  logic                    overrun_q;
  logic [FRAME_BITS-1:0]   sr_q;
  logic [CNT_W-1:0]        bit_cnt_q;

  logic signed [Width-1:0]  band_sel;
  logic signed [GW-1:0]     gain_sel;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  acc_scaled;
  logic [Width-1:0]         mix_sat;
  logic [DAC_CLAMP_W-1:0]   ys;
  logic [FRAME_BITS-1:0]    frame;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (enable) state_d = ST_MAC;
      ST_MAC:   if (idx_q == 2'd2) state_d = ST_SAT;
      ST_SAT:   state_d = ST_SHIFT;
      ST_SHIFT: if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    band_sel = band_q[0];
    gain_sel = gain_q[0];
    case (idx_q)
      2'd1: begin
        band_sel = band_q[1];
        gain_sel = gain_q[1];
      end
      2'd2: begin
        band_sel = band_q[2];
        gain_sel = gain_q[2];
      end
      default: ;
    endcase
    prod       = PROD_W'(band_sel) * PROD_W'(gain_sel);
    acc_sum    = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    acc_scaled = acc_sum >>> FRAC_SHIFT;
    frame      = {{(FRAME_BITS-DAC_BITS){1'b0}}, dac_code(ys)};
  end

  // The last MAC cycle saturates the completed sum directly, so yk_mix and
  // mix_valid are both registered and appear together in the SAT cycle.
  saturacion #(.IN_W(ACC_W), .OUT_W(Width)) u_sat_mix (
    .d_i (acc_scaled),
    .q_o (mix_sat)
  );

  saturacion #(.IN_W(Width), .OUT_W(DAC_CLAMP_W)) u_sat_dac (
    .d_i (yk_mix_q),
    .q_o (ys)
  );

  always_ff @(posedge sclk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        band_q[i] <= '0;
        gain_q[i] <= '0;
      end
      idx_q       <= '0;
      acc_q       <= '0;
      yk_mix_q    <= '0;
      mix_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
    end else begin
      mix_valid_q <= 1'b0;
      if (enable && (state_q != ST_IDLE)) overrun_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            band_q[0] <= yk_HPBass;
            band_q[1] <= yk_HPMed;
            band_q[2] <= yk_HPHigh;
            gain_q[0] <= g_bass;
            gain_q[1] <= g_med;
            gain_q[2] <= g_high;
            acc_q     <= '0;
            idx_q     <= '0;
          end
        end
        ST_MAC: begin
          acc_q <= acc_sum;
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd2) begin
            yk_mix_q    <= mix_sat;
            mix_valid_q <= 1'b1;
          end
        end
        ST_SAT: begin
          sr_q      <= frame;
          bit_cnt_q <= '0;
        end
        ST_SHIFT: begin
          sr_q      <= {sr_q[FRAME_BITS-2:0], 1'b0};
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign yk_mix      = yk_mix_q;
  assign mix_valid   = mix_valid_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != ST_IDLE);
  assign dac_cs_n    = (state_q != ST_SHIFT);
  assign dac_din     = (state_q == ST_SHIFT) & sr_q[FRAME_BITS-1];
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mezclador_dac.sv
// Directed bench for mezclador_dac: vector table of frames plus hand-written
// sequences for overrun, reset mid-frame and output hold.
module tb_mezclador_dac;
  import mezclador_dac_pkg::*;

  localparam int W = PKG_WIDTH;
  localparam int G = PKG_GW;

  logic         sclk = 1'b0;
  logic         rst;
  logic         enable;
  logic [W-1:0] yk_HPBass, yk_HPMed, yk_HPHigh;
  logic [G-1:0] g_bass, g_med, g_high;
  logic [W-1:0] yk_mix;
  logic         mix_valid, dac_cs_n, dac_din, busy, overrun;
  logic [1:0]   dbg_state;

  mezclador_dac dut (
    .sclk        (sclk),
    .rst         (rst),
    .enable      (enable),
    .yk_HPBass   (yk_HPBass),
    .yk_HPMed    (yk_HPMed),
    .yk_HPHigh   (yk_HPHigh),
    .g_bass      (g_bass),
    .g_med       (g_med),
    .g_high      (g_high),
    .yk_mix      (yk_mix),
    .mix_valid   (mix_valid),
    .dac_cs_n    (dac_cs_n),
    .dac_din     (dac_din),
    .busy        (busy),
    .overrun     (overrun),
    .dbg_state_o (dbg_state)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    string        name;
    logic [W-1:0] bass, med, high;
    logic [G-1:0] gb, gm, gh;
    logic [W-1:0] exp_mix;
    logic [15:0]  exp_frame;
  } vec_t;

  vec_t vecs[10];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // Drives one frame from cycle 0 (enable) to cycle 21 (back in IDLE) without
  // advancing past cycle 21; extra_en injects a second enable at that cycle.
  task automatic do_frame(input vec_t v, input int extra_en);
    int           mv_cnt, mv_cyc, low_cnt, first_low;
    logic [15:0]  frame;
    logic [W-1:0] got_mix;
    mv_cnt = 0; mv_cyc = -1; low_cnt = 0; first_low = -1;
    frame = '0; got_mix = '0;
    yk_HPBass = v.bass; yk_HPMed = v.med; yk_HPHigh = v.high;
    g_bass = v.gb; g_med = v.gm; g_high = v.gh;
    enable = 1'b1;
    tick();
    for (int c = 1; c <= 21; c++) begin
      if (c == 1) begin
        yk_HPBass = W'($urandom); yk_HPMed = W'($urandom); yk_HPHigh = W'($urandom);
        g_bass = G'($urandom); g_med = G'($urandom); g_high = G'($urandom);
      end
      if (mix_valid) begin
        mv_cnt++;
        mv_cyc  = c;
        got_mix = yk_mix;
      end
      if (!dac_cs_n) begin
        low_cnt++;
        frame = {frame[14:0], dac_din};
        if (first_low < 0) first_low = c;
      end
      if (c == 21) begin
        check({v.name, " cs_n@21"}, 32'(dac_cs_n), 32'd1);
        check({v.name, " din@21"}, 32'(dac_din), 32'd0);
        check({v.name, " busy@21"}, 32'(busy), 32'd0);
      end
      enable = (c == extra_en);
      if (c < 21) tick();
    end
    check({v.name, " mix_valid count"}, 32'(mv_cnt), 32'd1);
    check({v.name, " mix_valid cycle"}, 32'(mv_cyc), 32'd4);
    check({v.name, " yk_mix"}, 32'(got_mix), 32'(v.exp_mix));
    check({v.name, " cs_n first low"}, 32'(first_low), 32'd5);
    check({v.name, " cs_n low cycles"}, 32'(low_cnt), 32'd16);
    check({v.name, " frame"}, 32'(frame), 32'(v.exp_frame));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows, pulses;
    logic [W-1:0] held;

    vecs[0] = '{"half",     25'h0002000, 25'h0, 25'h0, 16'h4000, 16'h4000, 16'h4000, 25'h0002000, 16'h0C00};
    vecs[1] = '{"neg_half", 25'h1FFE000, 25'h0, 25'h0, 16'h4000, 16'h4000, 16'h4000, 25'h1FFE000, 16'h0400};
    vecs[2] = '{"pos_sat",  25'h0FFFFFF, 25'h0FFFFFF, 25'h0FFFFFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 25'h0FFFFFF, 16'h0FFF};
    vecs[3] = '{"neg_sat",  25'h1000000, 25'h1000000, 25'h1000000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 25'h1000000, 16'h0000};
    vecs[4] = '{"gain_mix", 25'h0001000, 25'h0001000, 25'h0001000, 16'h4000, 16'h2000, 16'hC000, 25'h0000800, 16'h0900};
    vecs[5] = '{"trunc_pos",25'h0000001, 25'h0, 25'h0, 16'h2000, 16'h0, 16'h0, 25'h0000000, 16'h0800};
    vecs[6] = '{"trunc_neg",25'h1FFFFFF, 25'h0, 25'h0, 16'h2000, 16'h0, 16'h0, 25'h1FFFFFF, 16'h07FF};
    vecs[7] = '{"dac_hi",   25'h0004000, 25'h0, 25'h0, 16'h4000, 16'h0, 16'h0, 25'h0004000, 16'h0FFF};
    vecs[8] = '{"dac_lo",   25'h1FFBFFF, 25'h0, 25'h0, 16'h4000, 16'h0, 16'h0, 25'h1FFBFFF, 16'h0000};
    vecs[9] = '{"three_band",25'h0002000, 25'h0001000, 25'h1FFF000, 16'h4000, 16'h2000, 16'hC000, 25'h0003800, 16'h0F00};

    // Reset with a coincident enable, which must be ignored.
    rst = 1'b1; enable = 1'b1;
    yk_HPBass = vecs[0].bass; yk_HPMed = '0; yk_HPHigh = '0;
    g_bass = 16'h4000; g_med = 16'h4000; g_high = 16'h4000;
    tick();
    tick();
    rst = 1'b0; enable = 1'b0;
    check("reset yk_mix", 32'(yk_mix), 32'd0);
    check("reset mix_valid", 32'(mix_valid), 32'd0);
    check("reset cs_n", 32'(dac_cs_n), 32'd1);
    check("reset din", 32'(dac_din), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset overrun", 32'(overrun), 32'd0);
    tick();
    check("enable with rst ignored", 32'(busy), 32'd0);

    for (int i = 0; i < 10; i++) do_frame(vecs[i], -1);
    check("table overrun clear", 32'(overrun), 32'd0);

    // yk_mix holds between pulses.
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (mix_valid) pulses++;
      held = yk_mix;
      tick();
    end
    check("hold pulses", 32'(pulses), 32'd0);
    check("hold yk_mix", 32'(held), 32'(vecs[9].exp_mix));

    // Enable at cycle 6 dropped, then enable at cycle 21 accepted.
    do_frame(vecs[0], 6);
    check("overrun after cycle-6 enable", 32'(overrun), 32'd1);
    do_frame(vecs[1], -1);
    check("overrun sticky", 32'(overrun), 32'd1);

    // Reset at SHIFT bit 8 of a frame whose remaining bits are ones.
    yk_HPBass = vecs[2].bass; yk_HPMed = vecs[2].med; yk_HPHigh = vecs[2].high;
    g_bass = vecs[2].gb; g_med = vecs[2].gm; g_high = vecs[2].gh;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    repeat (12) tick();
    check("mid-shift cs_n low", 32'(dac_cs_n), 32'd0);
    check("mid-shift bit8", 32'(dac_din), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst mid-shift cs_n", 32'(dac_cs_n), 32'd1);
    check("rst mid-shift din", 32'(dac_din), 32'd0);
    check("rst mid-shift busy", 32'(busy), 32'd0);
    check("rst mid-shift overrun", 32'(overrun), 32'd0);
    check("rst mid-shift yk_mix", 32'(yk_mix), 32'd0);
    lows = 0;
    for (int k = 0; k < 20; k++) begin
      if (!dac_cs_n || dac_din || mix_valid) lows++;
      tick();
    end
    check("no bits after rst", 32'(lows), 32'd0);

    // Enable in the last SHIFT cycle is dropped; the next one is accepted.
    do_frame(vecs[4], 20);
    check("overrun after last-bit enable", 32'(overrun), 32'd1);
    do_frame(vecs[7], -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
